// File: rtl/dfp_arbiter_pkg.sv
// Shared types and constants for the dfp arbiter.
//   arb_state_t : arbiter FSM state (IDLE -> BUSY -> DONE -> IDLE)
//   LINE_W      : cacheline width in bits
//   LINE_OFS    : number of byte-offset bits inside a line (32-byte lines)
package dfp_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam int LINE_W   = 256;
  localparam int LINE_OFS = 5;

  // Clears the in-line byte offset so the downstream port always sees
  // a line-aligned address.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    logic [31:0] mask;
    mask = (32'd1 << LINE_OFS) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/dfp_arbiter.sv
// Two-to-one cacheline arbiter between the dcache and icache miss ports and
// the single line-level port of the cacheline adapter. One line transaction
// is in flight at a time: a winner is chosen in IDLE, its request is latched,
// forwarded downstream in BUSY, and completed with a one-cycle resp in DONE.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   p0_addr/read/write/wdata   dcache request (write = dirty-line writeback)
//   p0_rdata, p0_resp          dcache fill line and completion pulse
//   p1_addr/read               icache request (read-only)
//   p1_rdata, p1_resp          icache fill line and completion pulse
//   dn_addr/read/write/wdata   downstream request, driven from latched copies
//   dn_rdata, dn_resp          downstream fill line and completion pulse
//   o_dbg_state                current FSM state
//   o_dbg_starve_cnt           consecutive dcache wins while icache waited
//
// Handshake: an upstream port raises read (or write) and holds it, with
// stable address/data, until its resp pulse; it drops the request before the
// next IDLE sample. Downstream, read/write stay high until a one-cycle
// dn_resp, and dn_rdata is valid in that same cycle.
import dfp_arbiter_pkg::*;

module dfp_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       p0_addr,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [LINE_W-1:0] p0_wdata,
  output logic [LINE_W-1:0] p0_rdata,
  output logic              p0_resp,
  input  logic [31:0]       p1_addr,
  input  logic              p1_read,
  output logic [LINE_W-1:0] p1_rdata,
  output logic              p1_resp,
  output logic [31:0]       dn_addr,
  output logic              dn_read,
  output logic              dn_write,
  output logic [LINE_W-1:0] dn_wdata,
  input  logic [LINE_W-1:0] dn_rdata,
  input  logic              dn_resp,
  output arb_state_t        o_dbg_state,
  output logic [CNT_W-1:0]  o_dbg_starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic              r_owner;
  logic [31:0]       r_addr;
  logic              r_read;
  logic              r_write;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_p0_rdata;
  logic [LINE_W-1:0] r_p1_rdata;
  logic [CNT_W-1:0]  r_starve_cnt;

  logic w_p0_req;
  logic w_p1_req;
  logic w_any_req;
  logic w_grant1;

  assign w_p0_req  = p0_read | p0_write;
  assign w_p1_req  = p1_read;
  assign w_any_req = w_p0_req | w_p1_req;
  // Icache wins when alone, or when it has watched the dcache win
  // STARVE_LIMIT times in a row.
  assign w_grant1  = w_p1_req & (~w_p0_req | (r_starve_cnt == LIMIT));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_any_req) w_state_next = ARB_BUSY;
      ARB_BUSY: if (dn_resp)   w_state_next = ARB_DONE;
      ARB_DONE: w_state_next = ARB_IDLE;
      default:  w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        ARB_IDLE: begin
          if (!p1_read || (w_any_req && w_grant1)) begin
            r_starve_cnt <= '0;
          end else if (w_p0_req && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
          end
          if (w_any_req) begin
            r_owner <= w_grant1;
            if (w_grant1) begin
              r_addr  <= line_align(p1_addr);
              r_read  <= 1'b1;
              r_write <= 1'b0;
            end else begin
              r_addr  <= line_align(p0_addr);
              // An illegal read+write collapses to a writeback.
              r_read  <= ~p0_write;
              r_write <= p0_write;
              r_wdata <= p0_wdata;
            end
          end
        end
        ARB_BUSY: begin
          // A writeback returns no line, so the dcache fill register keeps
          // its previous contents.
          if (dn_resp && r_read) begin
            if (r_owner) r_p1_rdata <= dn_rdata;
            else         r_p0_rdata <= dn_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign dn_addr  = r_addr;
  assign dn_read  = (r_state == ARB_BUSY) & r_read;
  assign dn_write = (r_state == ARB_BUSY) & r_write;
  assign dn_wdata = r_wdata;
  assign p0_resp  = (r_state == ARB_DONE) & ~r_owner;
  assign p1_resp  = (r_state == ARB_DONE) &  r_owner;
  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;

  a_p0_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(p0_read && p0_write));

endmodule

// File: tb/tb_dfp_arbiter.sv
// Bench for dfp_arbiter: directed scenarios, a transaction-level reference
// model advanced on every clock edge, and a per-cycle comparison of all
// DUT outputs against that model plus literal expectations per scenario.
import dfp_arbiter_pkg::*;

module tb_dfp_arbiter;

  localparam int LIMIT = 4;
  localparam logic [255:0] JUNK = {8{32'hDEAD_BEEF}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  p0_addr = '0, p1_addr = '0;
  logic         p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0;
  logic [255:0] p0_wdata = '0, dn_rdata = '0;
  logic         dn_resp = 1'b0;
  logic [255:0] p0_rdata, p1_rdata, dn_wdata;
  logic         p0_resp, p1_resp, dn_read, dn_write;
  logic [31:0]  dn_addr;
  arb_state_t   dbg_state;
  logic [3:0]   dbg_starve;

  dfp_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_read(p0_read), .p0_write(p0_write),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_resp(p0_resp),
    .p1_addr(p1_addr), .p1_read(p1_read), .p1_rdata(p1_rdata),
    .p1_resp(p1_resp),
    .dn_addr(dn_addr), .dn_read(dn_read), .dn_write(dn_write),
    .dn_wdata(dn_wdata), .dn_rdata(dn_rdata), .dn_resp(dn_resp),
    .o_dbg_state(dbg_state), .o_dbg_starve_cnt(dbg_starve)
  );

  // ---------------- reference model ----------------
  // m_phase: 0 = no transaction, 1 = downstream outstanding, 2 = returning.
  bit           m_valid = 1'b0;
  int           m_phase, m_starve;
  bit           m_owner, m_wr, m_p0req, m_pick1;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata, m_rd0, m_rd1;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_phase = 0; m_starve = 0; m_owner = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
    end else if (m_valid) begin
      case (m_phase)
        0: begin
          m_p0req = p0_read || p0_write;
          m_pick1 = p1_read && (!m_p0req || m_starve == LIMIT);
          if (m_p0req || p1_read) begin
            m_owner = m_pick1;
            m_addr  = (m_pick1 ? p1_addr : p0_addr) & 32'hFFFF_FFE0;
            m_wr    = !m_pick1 && p0_write;
            if (!m_pick1) m_wdata = p0_wdata;
            m_phase = 1;
          end
          if (!p1_read || m_pick1) m_starve = 0;
          else if (m_p0req && m_starve < LIMIT) m_starve = m_starve + 1;
        end
        1: if (dn_resp) begin
          if (!m_wr) begin
            if (m_owner) m_rd1 = dn_rdata;
            else         m_rd0 = dn_rdata;
          end
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0, n_total = 0;
  logic [31:0] exp_q[$];   // expected order of downstream line addresses

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- environment / driver tasks ----------------
  int cyc = 0, wait_cnt = 0, dn_delay = 0;
  bit resp_en = 1'b1, p0_hold = 1'b0, dn_act_q = 1'b0;
  bit saw_dn_read, saw_dn_write;
  int n_p0_resp, n_p1_resp, first_resp_port, first_dn_cyc, p1_resp_cyc;
  logic [31:0]  addr_log[$];
  logic [255:0] wdata_seen;

  task automatic clear_obs();
    addr_log.delete(); exp_q.delete();
    n_p0_resp = 0; n_p1_resp = 0; first_resp_port = -1;
    first_dn_cyc = -1; p1_resp_cyc = -1; wait_cnt = 0;
    saw_dn_read = 1'b0; saw_dn_write = 1'b0; wdata_seen = '0;
  endtask

  // One clock: compare against the model, observe, then play the
  // downstream memory and the upstream requesters.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      check1("dn_read", dn_read, m_phase == 1 && !m_wr);
      check1("dn_write", dn_write, m_phase == 1 && m_wr);
      check32("dn_addr", dn_addr, m_addr);
      if (m_phase == 1 && m_wr) check256("dn_wdata", dn_wdata, m_wdata);
      check1("p0_resp", p0_resp, m_phase == 2 && !m_owner);
      check1("p1_resp", p1_resp, m_phase == 2 && m_owner);
      check256("p0_rdata", p0_rdata, m_rd0);
      check256("p1_rdata", p1_rdata, m_rd1);
      checki("starve_cnt", int'(dbg_starve), m_starve);
    end
    if ((dn_read || dn_write) && !dn_act_q) begin
      addr_log.push_back(dn_addr);
      if (first_dn_cyc < 0) first_dn_cyc = cyc;
    end
    dn_act_q = dn_read || dn_write;
    if (dn_read) saw_dn_read = 1'b1;
    if (dn_write) begin saw_dn_write = 1'b1; wdata_seen = dn_wdata; end
    if (p0_resp) begin n_p0_resp++; if (first_resp_port < 0) first_resp_port = 0; end
    if (p1_resp) begin n_p1_resp++; p1_resp_cyc = cyc; if (first_resp_port < 0) first_resp_port = 1; end
    if (dn_resp) dn_resp = 1'b0;
    else if (resp_en && (dn_read || dn_write)) begin
      if (wait_cnt >= dn_delay) begin
        dn_resp  = 1'b1;
        dn_rdata = dn_write ? JUNK : {8{dn_addr}};
        wait_cnt = 0;
      end else wait_cnt++;
    end
    if (p0_resp && !p0_hold) begin p0_read = 1'b0; p0_write = 1'b0; end
    if (p1_resp) p1_read = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && (p0_read || p0_write || p1_read || dbg_state != ARB_IDLE)) begin
      tick(); n++;
    end
    check1({name, "_timeout"}, n >= budget, 1'b0);
  endtask

  task automatic wait_dn(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(dn_read || dn_write)) begin tick(); n++; end
    check1({name, "_timeout"}, n >= budget, 1'b0);
  endtask

  // ---------------- directed scenarios ----------------
  int req_cyc, grant_idx, starve_at_grant, n;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    check1("rst_dn_read", dn_read, 1'b0);
    check1("rst_dn_write", dn_write, 1'b0);
    check32("rst_dn_addr", dn_addr, 32'h0);
    check1("rst_p0_resp", p0_resp, 1'b0);
    check1("rst_p1_resp", p1_resp, 1'b0);
    check256("rst_p0_rdata", p0_rdata, 256'h0);
    check256("rst_p1_rdata", p1_rdata, 256'h0);
    check32("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
    rst = 1'b0;
    tick();

    // Lone icache read, unaligned address, downstream answers 2 cycles late
    clear_obs(); dn_delay = 2;
    p1_addr = 32'h6000_0024; p1_read = 1'b1; req_cyc = cyc;
    wait_idle("t1", 30);
    checki("t1_n_txn", addr_log.size(), 1);
    if (addr_log.size() > 0) check32("t1_dn_addr", addr_log[0], 32'h6000_0020);
    check1("t1_saw_read", saw_dn_read, 1'b1);
    checki("t1_grant_lat", first_dn_cyc - req_cyc, 1);
    checki("t1_resp_lat", p1_resp_cyc - first_dn_cyc, 3);
    checki("t1_n_p1_resp", n_p1_resp, 1);
    checki("t1_n_p0_resp", n_p0_resp, 0);
    check256("t1_p1_rdata", p1_rdata, {8{32'h6000_0020}});

    // Simultaneous requests: dcache first, then icache
    clear_obs(); dn_delay = 0;
    exp_q.push_back(32'h0000_1000); exp_q.push_back(32'h0000_2000);
    p0_addr = 32'h0000_1000; p0_read = 1'b1;
    p1_addr = 32'h0000_2000; p1_read = 1'b1;
    wait_idle("t2", 40);
    checki("t2_n_txn", addr_log.size(), exp_q.size());
    for (int i = 0; i < addr_log.size() && i < exp_q.size(); i++)
      check32("t2_order", addr_log[i], exp_q[i]);
    checki("t2_first_resp", first_resp_port, 0);
    checki("t2_n_p0_resp", n_p0_resp, 1);
    checki("t2_n_p1_resp", n_p1_resp, 1);
    check256("t2_p0_rdata", p0_rdata, {8{32'h0000_1000}});
    check256("t2_p1_rdata", p1_rdata, {8{32'h0000_2000}});

    // Dcache writeback
    clear_obs(); dn_delay = 1;
    p0_addr = 32'h0000_3040; p0_wdata = {32{8'hA5}}; p0_write = 1'b1;
    wait_idle("t3", 30);
    p0_wdata = '0;
    check1("t3_saw_write", saw_dn_write, 1'b1);
    check1("t3_no_read", saw_dn_read, 1'b0);
    check256("t3_dn_wdata", wdata_seen, {32{8'hA5}});
    if (addr_log.size() > 0) check32("t3_dn_addr", addr_log[0], 32'h0000_3040);
    checki("t3_n_p0_resp", n_p0_resp, 1);
    check256("t3_p0_rdata_kept", p0_rdata, {8{32'h0000_1000}});

    // Starvation: dcache keeps asking, icache must win on arbitration 5
    clear_obs(); dn_delay = 0; p0_hold = 1'b1;
    p0_addr = 32'h0000_4000; p0_read = 1'b1;
    p1_addr = 32'h0000_5000; p1_read = 1'b1;
    grant_idx = 0; starve_at_grant = -1; n = 0;
    while (n < 80 && n_p1_resp == 0) begin
      tick(); n++;
      if (grant_idx == 0 && addr_log.size() > 0 && addr_log[$] == 32'h0000_5000) begin
        grant_idx = addr_log.size();
        starve_at_grant = int'(dbg_starve);
      end
    end
    check1("t4_timeout", n >= 80, 1'b0);
    checki("t4_grant_idx", grant_idx, 5);
    checki("t4_p0_before", n_p0_resp, 4);
    checki("t4_starve_after", starve_at_grant, 0);
    p0_hold = 1'b0;
    wait_idle("t4_drain", 40);

    // Reset in the middle of BUSY, then a stray downstream resp
    clear_obs(); resp_en = 1'b0;
    p0_addr = 32'h0000_7000; p0_read = 1'b1;
    wait_dn("t5", 10);
    rst = 1'b1; p0_read = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    dn_rdata = JUNK; dn_resp = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checki("t5_n_p0_resp", n_p0_resp, 0);
    checki("t5_n_p1_resp", n_p1_resp, 0);
    check1("t5_dn_read", dn_read, 1'b0);
    check1("t5_dn_write", dn_write, 1'b0);
    check32("t5_dn_addr", dn_addr, 32'h0);
    check256("t5_p0_rdata", p0_rdata, 256'h0);
    check32("t5_state", 32'(dbg_state), 32'(ARB_IDLE));
    resp_en = 1'b1;

    // Address changes while BUSY must not reach downstream
    clear_obs(); dn_delay = 3;
    p0_addr = 32'h0000_8000; p0_read = 1'b1;
    wait_dn("t6", 10);
    p0_addr = 32'h0000_9000;
    n = 0;
    while (n < 20 && n_p0_resp == 0) begin
      if (dn_read) check32("t6_dn_addr_busy", dn_addr, 32'h0000_8000);
      tick(); n++;
    end
    check1("t6_timeout", n >= 20, 1'b0);
    wait_idle("t6_idle", 10);
    check32("t6_dn_addr_idle", dn_addr, 32'h0000_8000);
    check1("t6_dn_read_idle", dn_read, 1'b0);
    check256("t6_p0_rdata", p0_rdata, {8{32'h0000_8000}});
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dfp_arbiter.md
Name: dfp_arbiter

Overview:
- Shares one downstream cacheline port between two upstream cache miss ports.
- Port 0 is the dcache dfp (read/write, write = dirty-line writeback); port 1 is the icache dfp (read-only).
- Sits between the two caches' dfp ports and the cacheline adapter's single line-level port.
- Holds exactly one line transaction in flight: grants, latches, forwards, returns response.

Parameters:
- STARVE_LIMIT, 4, consecutive port-0 grants while port 1 is pending before port 1 is forced to win (range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p0_addr  in  32  dcache line address (bits [4:0] ignored, forced to 0 downstream)
- p0_read  in  1  dcache line read request, held until p0_resp
- p0_write  in  1  dcache line writeback request, held until p0_resp
- p0_wdata  in  256  writeback line
- p0_rdata  out  256  fill line
- p0_resp  out  1  one-cycle completion pulse
- p1_addr  in  32  icache line address
- p1_read  in  1  icache line read request, held until p1_resp
- p1_rdata  out  256  fill line
- p1_resp  out  1  one-cycle completion pulse
- dn_addr  out  32  downstream line address, 32-byte aligned
- dn_read  out  1  downstream read
- dn_write  out  1  downstream write
- dn_wdata  out  256  downstream write line
- dn_rdata  in  256  downstream fill line
- dn_resp  in  1  downstream completion, one cycle

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, owner=0, starve_cnt=0, all outputs 0, rdata registers 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: sample the requests. If none is pending, stay in IDLE. Otherwise choose a winner:
  - port 1 wins if only port 1 requests, or if both request and starve_cnt == STARVE_LIMIT;
  - else port 0 wins.
  - Latch owner, addr (low 5 bits cleared), read/write and wdata into registers, then go to BUSY.
- Starvation counter:
  - incremented when port 0 wins while p1_read=1 (saturates at STARVE_LIMIT);
  - cleared when port 1 wins or when p1_read=0 in IDLE.
- BUSY: dn_read/dn_write/dn_addr/dn_wdata driven from registers only, never from live inputs. Hold until dn_resp=1, then capture dn_rdata into the owner's rdata register and go to DONE.
- DONE, one cycle:
  - owner's resp=1 and rdata valid; the other port's resp=0;
  - dn_read=dn_write=0;
  - next state IDLE. The requester is guaranteed to have dropped its request by the following IDLE sample.
- Latency: grant at edge E; dn_* asserted from E+1; dn_resp at cycle T gives upstream resp at T+1. Minimum 3 cycles request-to-resp with a zero-wait downstream.
- p0_read and p0_write both high is illegal: write wins, and the simulation assertion fires.
- Requests arriving during BUSY/DONE wait; they are not dropped.
- Downstream resp while IDLE (including after a reset mid-transaction) is ignored; no upstream resp is generated.
- p*_rdata holds its last captured value outside DONE.
- dn_addr keeps its last value in IDLE, but dn_read/dn_write stay 0 there.

Decomposition:
- Add to rv32i_types: enum arb_state_t {ARB_IDLE, ARB_BUSY, ARB_DONE}; localparam LINE_W=256; localparam LINE_OFS=5.
- No sub-module; the starvation counter stays inline.

Test Plan:
- Lone icache read to 0x6000_0024, downstream resp 2 cycles after dn_read → dn_addr=0x6000_0020, dn_read=1, p1_rdata=dn_rdata, p1_resp one cycle at T+1, p0_resp=0 throughout.
- Simultaneous p0_read 0x1000 and p1_read 0x2000 → dcache served first. Then icache is served, with dn_addr 0x1000 then 0x2000 and exactly one resp each.
- Dcache writeback, p0_wdata=256'hA5..A5 to 0x3040 → dn_write=1, dn_wdata matches, dn_read=0, p0_resp pulse, p0_rdata unchanged.
- Starvation: p0_read held high continuously (re-asserting after each resp), p1_read held high → icache granted no later than the 5th arbitration (STARVE_LIMIT=4), then starve_cnt=0.
- Reset asserted during BUSY, then a stray dn_resp one cycle after reset → all outputs 0, no p0_resp/p1_resp, state IDLE.
- Requester changes p0_addr while BUSY → dn_addr stays at the latched value until DONE.
